// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, data word, flag bundle and the ALU arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OP_W-1:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    // Bit order matches the {negative, overflow, zero} flag bus.
    typedef struct packed {
        logic negative;
        logic overflow;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches last+1 .. last+NREQ (mod NREQ)
// over req with masked bits removed and reports the first hit.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IDW-1:0]  last,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    logic [NREQ-1:0] cand;
    logic [IDW-1:0]  idx;

    // Walk from the farthest slot back to the nearest so the nearest hit wins.
    always_comb begin
        cand   = req & ~mask;
        valid  = |cand;
        winner = '0;
        idx    = '0;
        for (int unsigned off = NREQ; off >= 1; off--) begin
            idx = IDW'((32'(last) + off) % NREQ);
            if (cand[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin req/ack front end that time-shares one combinational ALU.
// Operands are registered at grant, results/flags registered after the ALU slot.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester saturating overflow counters.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    parameter  int unsigned CNTW = 16,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0][OP_W-1:0]    req_aluop,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_porta,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_portb,
    output logic [NREQ-1:0]              ack,
    output word_t                        rsp_porto,
    output alu_flags_t                   rsp_flags,
    output logic                         busy,
    output aluop_t                       alu_aluop,
    output word_t                        alu_porta,
    output word_t                        alu_portb,
    input  word_t                        alu_porto,
    input  alu_flags_t                   alu_flags
`ifdef ALU_ARB_STATS_EN
   ,output logic [NREQ-1:0][CNTW-1:0]    ovf_count
`endif
);

    generate
        if (NREQ < 2 || NREQ > 8 || CNTW < 1) begin : g_param_check
            $error("alu_arbiter: NREQ must be 2..8 and CNTW at least 1");
        end
    endgenerate

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   last_q, last_d;
    aluop_t           aluop_d;
    word_t            porta_d, portb_d;
    logic [NREQ-1:0]  ack_d;
    word_t            porto_d;
    alu_flags_t       flags_d;
    logic             busy_d;
    logic             take;

    logic [NREQ-1:0]  pick_mask;
    logic [IDW-1:0]   pick_last;
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][CNTW-1:0] ovf_d;
`endif

    // In RESP the requester just served is excluded and the search starts after it.
    always_comb begin
        pick_mask = '0;
        pick_last = last_q;
        if (state_q == RESP) begin
            pick_mask = NREQ'(1) << gnt_q;
            pick_last = gnt_q;
        end
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req),
        .mask   (pick_mask),
        .last   (pick_last),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    // Next-state and next-register values for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        aluop_d = alu_aluop;
        porta_d = alu_porta;
        portb_d = alu_portb;
        ack_d   = '0;
        porto_d = rsp_porto;
        flags_d = rsp_flags;
        take    = 1'b0;
`ifdef ALU_ARB_STATS_EN
        ovf_d   = ovf_count;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    take = 1'b1;
                end
            end
            ISSUE: begin
                porto_d = alu_porto;
                flags_d = alu_flags;
                ack_d   = NREQ'(1) << gnt_q;
                aluop_d = aluop_t'(OP_W'(0));
                porta_d = '0;
                portb_d = '0;
                state_d = RESP;
`ifdef ALU_ARB_STATS_EN
                if (alu_flags.overflow && (ovf_count[gnt_q] != '1)) begin
                    ovf_d[gnt_q] = ovf_count[gnt_q] + CNTW'(1);
                end
`endif
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
                if (pick_valid) begin
                    take = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant: capture the winner's operands so later changes cannot leak in.
        if (take) begin
            gnt_d   = pick_id;
            aluop_d = aluop_t'(req_aluop[pick_id]);
            porta_d = req_porta[pick_id];
            portb_d = req_portb[pick_id];
            state_d = ISSUE;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= IDW'(NREQ - 1);
            alu_aluop <= aluop_t'(OP_W'(0));
            alu_porta <= '0;
            alu_portb <= '0;
            ack       <= '0;
            rsp_porto <= '0;
            rsp_flags <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            alu_aluop <= aluop_d;
            alu_porta <= porta_d;
            alu_portb <= portb_d;
            ack       <= ack_d;
            rsp_porto <= porto_d;
            rsp_flags <= flags_d;
            busy      <= busy_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester overflow event counters, saturating at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf_count <= '0;
        end else begin
            ovf_count <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model. Also builds with ALU_ARB_STATS_EN defined.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned CNTW = 16;

    logic                         CLK;
    logic                         nRST;
    logic [NREQ-1:0]              req;
    logic [NREQ-1:0][OP_W-1:0]    req_aluop;
    logic [NREQ-1:0][WORD_W-1:0]  req_porta;
    logic [NREQ-1:0][WORD_W-1:0]  req_portb;
    logic [NREQ-1:0]              ack;
    word_t                        rsp_porto;
    alu_flags_t                   rsp_flags;
    logic                         busy;
    aluop_t                       alu_aluop;
    word_t                        alu_porta;
    word_t                        alu_portb;
    word_t                        alu_porto;
    alu_flags_t                   alu_flags;
    logic [34:0]                  alu_r;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][CNTW-1:0]    ovf_count;
`endif

    int n_cmp;
    int n_bad;

    alu_arbiter #(
        .NREQ (NREQ),
        .CNTW (CNTW)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .req_aluop (req_aluop),
        .req_porta (req_porta),
        .req_portb (req_portb),
        .ack       (ack),
        .rsp_porto (rsp_porto),
        .rsp_flags (rsp_flags),
        .busy      (busy),
        .alu_aluop (alu_aluop),
        .alu_porta (alu_porta),
        .alu_portb (alu_portb),
        .alu_porto (alu_porto),
        .alu_flags (alu_flags)
`ifdef ALU_ARB_STATS_EN
       ,.ovf_count (ovf_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU: returns {result, negative, overflow, zero}.
    function automatic logic [34:0] alu_eval(input logic [3:0] op, input word_t a, input word_t b);
        word_t r;
        logic  v;
        r = '0;
        v = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            default:  r = '0;
        endcase
        return {r, r[31], v, (r == '0)};
    endfunction

    assign alu_r     = alu_eval(alu_aluop, alu_porta, alu_portb);
    assign alu_porto = alu_r[34:3];
    assign alu_flags = alu_flags_t'(alu_r[2:0]);

    function automatic logic [3:0] pick_op(input int unsigned k);
        case (k)
            0: return ALU_SLL;
            1: return ALU_SRL;
            2: return ALU_ADD;
            3: return ALU_SUB;
            4: return ALU_AND;
            5: return ALU_OR;
            6: return ALU_XOR;
            7: return ALU_NOR;
            8: return ALU_SLT;
            default: return ALU_SLTU;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req       = '0;
        req_aluop = '0;
        req_porta = '0;
        req_portb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic set_op(input int r, input logic [3:0] op, input word_t a, input word_t b);
        req_aluop[r] = op;
        req_porta[r] = a;
        req_portb[r] = b;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #1;
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rsp_porto !== 32'h0) begin n_bad++; $display("FAIL reset_porto: got %h want 0", rsp_porto); end
        n_cmp++; if (alu_aluop !== ALU_SLL) begin n_bad++; $display("FAIL reset_aluop: got %h want 0", alu_aluop); end
        tick();
        tick();
        nRST = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || ack !== 2'b00) begin n_bad++; $display("FAIL reset_idle: busy %b ack %b want 0 00", busy, ack); end
    endtask

    task automatic test_single_op();
        do_reset();
        req[0] = 1'b1;
        set_op(0, ALU_ADD, 32'd5, 32'd7);
        tick();
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL single_early_ack: got %b want 00", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (alu_aluop !== ALU_ADD || alu_porta !== 32'd5 || alu_portb !== 32'd7) begin
            n_bad++; $display("FAIL single_issue: got op %h a %h b %h want 2 5 7", alu_aluop, alu_porta, alu_portb);
        end
        req_porta[0] = 32'd99;
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", ack); end
        n_cmp++; if (rsp_porto !== 32'd12) begin n_bad++; $display("FAIL single_porto: got %h want c", rsp_porto); end
        n_cmp++; if (rsp_flags !== 3'b000) begin n_bad++; $display("FAIL single_flags: got %b want 000", rsp_flags); end
        n_cmp++; if (alu_aluop !== ALU_SLL || alu_porta !== 32'd0) begin
            n_bad++; $display("FAIL single_alu_idle: got op %h a %h want 0 0", alu_aluop, alu_porta);
        end
        req = '0;
        tick();
        n_cmp++; if (ack !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL single_done: ack %b busy %b want 00 0", ack, busy); end
    endtask

    task automatic test_contention();
        do_reset();
        req = 2'b11;
        set_op(0, ALU_ADD, 32'd1, 32'd1);
        set_op(1, ALU_SUB, 32'd3, 32'd3);
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01 || rsp_porto !== 32'd2 || rsp_flags !== 3'b000) begin
            n_bad++; $display("FAIL contend_first: ack %b porto %h flags %b want 01 2 000", ack, rsp_porto, rsp_flags);
        end
        req[0] = 1'b0;
        tick();
        n_cmp++; if (ack !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL contend_gap: ack %b busy %b want 00 1", ack, busy); end
        tick();
        n_cmp++; if (ack !== 2'b10 || rsp_porto !== 32'd0 || rsp_flags !== 3'b001) begin
            n_bad++; $display("FAIL contend_second: ack %b porto %h flags %b want 10 0 001", ack, rsp_porto, rsp_flags);
        end
        req = '0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        req = 2'b10;
        set_op(1, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        tick();
        tick();
        n_cmp++; if (ack !== 2'b10 || rsp_porto !== 32'h8000_0000 || rsp_flags !== 3'b110) begin
            n_bad++; $display("FAIL overflow: ack %b porto %h flags %b want 10 80000000 110", ack, rsp_porto, rsp_flags);
        end
`ifdef ALU_ARB_STATS_EN
        n_cmp++; if (ovf_count[1] !== CNTW'(1) || ovf_count[0] !== CNTW'(0)) begin
            n_bad++; $display("FAIL ovf_count: got %0d %0d want 1 0", ovf_count[1], ovf_count[0]);
        end
`endif
        req = '0;
        tick();
    endtask

    task automatic test_fairness();
        int seen;
        do_reset();
        req = 2'b11;
        set_op(0, ALU_ADD, 32'd2, 32'd3);
        set_op(1, ALU_SUB, 32'd10, 32'd4);
        seen = 0;
        for (int cyc = 0; cyc < 40 && seen < 8; cyc++) begin
            tick();
            n_cmp++; if ($countones(ack) > 1) begin n_bad++; $display("FAIL fair_onehot: got %b", ack); end
            if (ack != '0) begin
                n_cmp++;
                if ((seen % 2) == 0) begin
                    if (ack !== 2'b01 || rsp_porto !== 32'd5) begin
                        n_bad++; $display("FAIL fair_order: ack#%0d got %b porto %h want 01 5", seen, ack, rsp_porto);
                    end
                end else begin
                    if (ack !== 2'b10 || rsp_porto !== 32'd6) begin
                        n_bad++; $display("FAIL fair_order: ack#%0d got %b porto %h want 10 6", seen, ack, rsp_porto);
                    end
                end
                seen++;
            end
        end
        n_cmp++; if (seen != 8) begin n_bad++; $display("FAIL fair_count: got %0d acks want 8", seen); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 2'b01;
        set_op(0, ALU_OR, 32'hF0, 32'h0F);
        tick();
        req = 2'b10;
        set_op(1, ALU_AND, 32'hFF, 32'h3C);
        tick();
        n_cmp++; if (ack !== 2'b01 || rsp_porto !== 32'hFF) begin
            n_bad++; $display("FAIL withdraw_ack: ack %b porto %h want 01 ff", ack, rsp_porto);
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL withdraw_noack: cycle %0d got %b want 00", i, ack); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL withdraw_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req = 2'b01;
        set_op(0, ALU_ADD, 32'd5, 32'd7);
        tick();
        tick();
        req = '0;
        tick();
        req = 2'b01;
        set_op(0, ALU_XOR, 32'd1, 32'd2);
        tick();
        #2;
        nRST = 1'b0;
        req  = '0;
        #1;
        n_cmp++; if (ack !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_ctl: ack %b busy %b want 00 0", ack, busy); end
        n_cmp++; if (rsp_porto !== 32'h0 || rsp_flags !== 3'b000) begin
            n_bad++; $display("FAIL midrst_rsp: porto %h flags %b want 0 000", rsp_porto, rsp_flags);
        end
        n_cmp++; if (alu_aluop !== ALU_SLL || alu_porta !== 32'h0) begin
            n_bad++; $display("FAIL midrst_alu: op %h a %h want 0 0", alu_aluop, alu_porta);
        end
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL midrst_noack: cycle %0d got %b want 00", i, ack); end
        end
        req = 2'b10;
        set_op(1, ALU_SUB, 32'd9, 32'd4);
        tick();
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL midrst_early: got %b want 00", ack); end
        tick();
        n_cmp++; if (ack !== 2'b10 || rsp_porto !== 32'd5) begin
            n_bad++; $display("FAIL midrst_next: ack %b porto %h want 10 5", ack, rsp_porto);
        end
        req = '0;
        tick();
    endtask

    task automatic new_ops(input int r);
        word_t a;
        word_t b;
        a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : word_t'($urandom());
        b = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : word_t'($urandom());
        set_op(r, pick_op($urandom_range(0, 9)), a, b);
    endtask

    // Each edge either completes the granted op or makes a round-robin decision
    // among sampled requests, skipping the requester acked just before.
    task automatic test_random();
        int              last;
        int              pend;
        int              masked;
        int              cool [NREQ];
        logic [34:0]     pend_res;
        logic [34:0]     exp_res;
        logic [3:0]      pend_op;
        logic [NREQ-1:0] exp_ack;
        logic [NREQ-1:0] s;
        logic            exp_busy;
        logic            found;
        do_reset();
        last   = NREQ - 1;
        pend   = -1;
        masked = -1;
        pend_res = '0;
        exp_res  = '0;
        pend_op  = '0;
        for (int r = 0; r < NREQ; r++) cool[r] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            s = req;
            if (pend >= 0) begin
                exp_ack = NREQ'(1) << pend;
                exp_res = pend_res;
                last    = pend;
                masked  = pend;
                pend    = -1;
            end else begin
                exp_ack = '0;
                found   = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (last + k) % NREQ;
                    if (!found && s[c] && c != masked) begin
                        found    = 1'b1;
                        pend     = c;
                        pend_op  = req_aluop[c];
                        pend_res = alu_eval(req_aluop[c], req_porta[c], req_portb[c]);
                    end
                end
                masked = -1;
            end
            exp_busy = (pend >= 0) || (exp_ack != '0);
            tick();
            n_cmp++; if (ack !== exp_ack || busy !== exp_busy) begin
                n_bad++; $display("FAIL rand_ctl: cycle %0d ack %b busy %b want %b %b", cyc, ack, busy, exp_ack, exp_busy);
            end
            if (exp_ack != '0) begin
                n_cmp++; if (rsp_porto !== exp_res[34:3] || rsp_flags !== exp_res[2:0]) begin
                    n_bad++; $display("FAIL rand_rsp: cycle %0d porto %h flags %b want %h %b", cyc, rsp_porto, rsp_flags, exp_res[34:3], exp_res[2:0]);
                end
            end
            if (pend >= 0) begin
                n_cmp++; if (alu_aluop !== pend_op) begin
                    n_bad++; $display("FAIL rand_issue: cycle %0d op %h want %h", cyc, alu_aluop, pend_op);
                end
            end else begin
                n_cmp++; if (alu_aluop !== ALU_SLL || alu_porta !== 32'h0 || alu_portb !== 32'h0) begin
                    n_bad++; $display("FAIL rand_alu_idle: cycle %0d op %h a %h b %h want 0", cyc, alu_aluop, alu_porta, alu_portb);
                end
            end
            for (int r = 0; r < NREQ; r++) begin
                if (exp_ack[r]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        new_ops(r);
                    end else begin
                        req[r]  = 1'b0;
                        cool[r] = int'($urandom_range(0, 3));
                    end
                end else if (pend == r) begin
                    if ($urandom_range(0, 1) == 1) new_ops(r);
                end else if (!req[r]) begin
                    if (cool[r] > 0) begin
                        cool[r]--;
                    end else if ($urandom_range(0, 2) != 0) begin
                        req[r] = 1'b1;
                        new_ops(r);
                    end
                end
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_op();
        test_contention();
        test_overflow();
        test_fairness();
        test_withdraw();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
